// File: rtl/hba_pkg.sv
// hba_pkg: shared HBA bus widths, arbiter state encoding and a one-hot index helper.
package hba_pkg;
    localparam int DBUS_W        = 8;
    localparam int PERIPH_ADDR_W = 4;
    localparam int REG_ADDR_W    = 8;
    localparam int MAX_MASTERS   = 8;
    localparam int IDX_W         = $clog2(MAX_MASTERS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [MAX_MASTERS-1:0] oh);
        onehot_idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++)
            if (oh[i]) onehot_idx = onehot_idx | IDX_W'(i);
    endfunction
endpackage

// File: rtl/hba_rr_pick.sv
// hba_rr_pick: combinational round-robin picker, searching upward from last+1 with wrap.
module hba_rr_pick
    import hba_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     pick,
    output logic             valid
);
    // Two passes: indices above last first, then the wrapped range up to last.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && i > int'(last)) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && i <= int'(last)) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/hba_arbiter.sv
// hba_arbiter: round-robin HBA bus arbiter with registered one-hot grant and
// combinational merge of the granted master's bus onto the shared slave bus.
module hba_arbiter
    import hba_pkg::*;
#(
    parameter int NUM_MASTERS       = 4,
    parameter int DBUS_WIDTH        = DBUS_W,
    parameter int PERIPH_ADDR_WIDTH = PERIPH_ADDR_W,
    parameter int REG_ADDR_WIDTH    = REG_ADDR_W,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH
) (
    input  logic                              hba_clk,
    input  logic                              hba_reset,
    input  logic [NUM_MASTERS-1:0]            master_request,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_abus,
    input  logic [NUM_MASTERS-1:0]            master_rnw,
    input  logic [NUM_MASTERS-1:0]            master_select,
    input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] master_dbus,
    output logic [NUM_MASTERS-1:0]            hba_mgrant,
    output logic [ADDR_WIDTH-1:0]             hba_abus,
    output logic                              hba_rnw,
    output logic                              hba_select,
    output logic [DBUS_WIDTH-1:0]             hba_dbus
);
    state_t                 state, state_nx;
    logic [NUM_MASTERS-1:0] grant_nx, pick;
    logic [IDX_W-1:0]       last, last_nx;
    logic                   pick_valid, owner_req;
    logic [ADDR_WIDTH-1:0]  abus_m [NUM_MASTERS];
    logic [DBUS_WIDTH-1:0]  dbus_m [NUM_MASTERS];

    hba_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req   (master_request),
        .last  (last),
        .pick  (pick),
        .valid (pick_valid)
    );

    assign owner_req = |(master_request & hba_mgrant);

    always_comb begin
        state_nx = state;
        grant_nx = hba_mgrant;
        last_nx  = last;
        case (state)
            IDLE: if (pick_valid) begin
                state_nx = OWNED;
                grant_nx = pick;
                last_nx  = onehot_idx(MAX_MASTERS'(pick));
            end
            OWNED: if (!owner_req && !hba_select) begin
                state_nx = RELEASE;
                grant_nx = '0;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge hba_clk or negedge hba_reset) begin
        if (!hba_reset) begin
            state      <= IDLE;
            hba_mgrant <= '0;
            last       <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state      <= state_nx;
            hba_mgrant <= grant_nx;
            last       <= last_nx;
        end
    end

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_mask
        assign abus_m[g] = master_abus[g*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{hba_mgrant[g]}};
        assign dbus_m[g] = master_dbus[g*DBUS_WIDTH +: DBUS_WIDTH] & {DBUS_WIDTH{hba_mgrant[g]}};
    end

    assign hba_rnw    = |(master_rnw & hba_mgrant);
    assign hba_select = |(master_select & hba_mgrant);

    always_comb begin
        hba_abus = '0;
        hba_dbus = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            hba_abus = hba_abus | abus_m[i];
            hba_dbus = hba_dbus | dbus_m[i];
        end
    end
endmodule

// File: tb/tb_hba_arbiter.sv
// tb_hba_arbiter: directed stimulus with an abstract owner/turnaround model checked every cycle.
module tb_hba_arbiter;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TENURE = 3;

    logic          clk = 1'b0;
    logic          hba_reset = 1'b0;
    logic [N-1:0]  man_req = '0, man_sel = '0, rnw = 4'b0101;
    logic [N-1:0]  auto_en = '0, auto_req = '0;
    logic [N-1:0]  req_bus, sel_bus;
    logic [AW-1:0] ab [N];
    logic [DW-1:0] db [N];
    logic [N*AW-1:0] abus_bus;
    logic [N*DW-1:0] dbus_bus;
    logic [N-1:0]  hba_mgrant;
    logic [AW-1:0] hba_abus;
    logic          hba_rnw, hba_select;
    logic [DW-1:0] hba_dbus;

    int vectors = 0;
    int miscompares = 0;
    int cnt [N];
    int owner = -1;
    int turn = 0;
    int last = N - 1;
    logic [N-1:0] prev_g = '0;
    logic [N-1:0] gq [$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_bus[i] = auto_en[i] ? auto_req[i] : man_req[i];
            sel_bus[i] = auto_en[i] ? auto_req[i] : man_sel[i];
            abus_bus[i*AW +: AW] = ab[i];
            dbus_bus[i*DW +: DW] = db[i];
        end
    end

    hba_arbiter #(.NUM_MASTERS(N)) dut (
        .hba_clk        (clk),
        .hba_reset      (hba_reset),
        .master_request (req_bus),
        .master_abus    (abus_bus),
        .master_rnw     (rnw),
        .master_select  (sel_bus),
        .master_dbus    (dbus_bus),
        .hba_mgrant     (hba_mgrant),
        .hba_abus       (hba_abus),
        .hba_rnw        (hba_rnw),
        .hba_select     (hba_select),
        .hba_dbus       (hba_dbus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Model: who owns the bus, and how many ungranted turnaround cycles remain.
    always @(posedge clk or negedge hba_reset) begin
        if (!hba_reset) begin
            owner = -1;
            turn  = 0;
            last  = N - 1;
        end else if (owner >= 0) begin
            if (!req_bus[owner] && !sel_bus[owner]) begin
                owner = -1;
                turn  = 1;
            end
        end else if (turn > 0) begin
            turn--;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (owner < 0 && req_bus[(last + k) % N]) begin
                    owner = (last + k) % N;
                    last  = owner;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("grant", 32'(hba_mgrant), owner >= 0 ? 32'(1) << owner : 32'd0);
        check("abus",  32'(hba_abus),   owner >= 0 ? 32'(ab[owner]) : 32'd0);
        check("dbus",  32'(hba_dbus),   owner >= 0 ? 32'(db[owner]) : 32'd0);
        check("rnw",   32'(hba_rnw),    owner >= 0 ? 32'(rnw[owner]) : 32'd0);
        check("select",32'(hba_select), owner >= 0 ? 32'(sel_bus[owner]) : 32'd0);
        if (hba_mgrant != '0 && hba_mgrant != prev_g) gq.push_back(hba_mgrant);
        prev_g = hba_mgrant;
    end

    // Reactive masters: request when idle, hold for TENURE granted cycles, then drop.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (!auto_en[i]) begin
                auto_req[i] = 1'b0;
                cnt[i] = 0;
            end else if (hba_mgrant[i]) begin
                cnt[i]++;
                if (cnt[i] >= TENURE) auto_req[i] = 1'b0;
            end else begin
                auto_req[i] = 1'b1;
                cnt[i] = 0;
            end
        end
    end

    task automatic do_reset();
        hba_reset = 1'b0;
        man_req = '0;
        man_sel = '0;
        auto_en = '0;
        tick(2);
        hba_reset = 1'b1;
        tick(1);
        gq.delete();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ab[i] = AW'(12'h100 * i + 12'h23);
            db[i] = DW'(8'h10 * i + 8'h5);
        end
        ab[0] = 12'h012;
        do_reset();
        check("reset_grant", 32'(hba_mgrant), 32'h0);

        // single request
        man_req = 4'b0001;
        man_sel = 4'b0001;
        tick(1);
        check("single_grant", 32'(hba_mgrant), 32'h1);
        check("single_abus", 32'(hba_abus), 32'h012);
        tick(2);
        man_req = '0;
        man_sel = '0;
        tick(1);
        check("single_rel1", 32'(hba_mgrant), 32'h0);
        tick(1);
        check("single_rel2", 32'(hba_mgrant), 32'h0);
        tick(2);

        // masking
        do_reset();
        db[0] = 8'h55;
        ab[2] = 12'hFFF;
        db[2] = 8'hAA;
        man_sel = 4'b0100;
        tick(1);
        check("mask_idle_abus", 32'(hba_abus), 32'h0);
        check("mask_idle_sel", 32'(hba_select), 32'h0);
        check("mask_idle_dbus", 32'(hba_dbus), 32'h0);
        man_req = 4'b0001;
        man_sel = 4'b0101;
        tick(1);
        check("mask_grant", 32'(hba_mgrant), 32'h1);
        check("mask_abus", 32'(hba_abus), 32'h012);
        check("mask_dbus", 32'(hba_dbus), 32'h55);
        check("mask_sel", 32'(hba_select), 32'h1);
        man_sel = 4'b0100;
        #1;
        check("mask_sel_owner0", 32'(hba_select), 32'h0);
        man_req = '0;
        tick(3);

        // select hold
        do_reset();
        man_req = 4'b0100;
        man_sel = 4'b0100;
        tick(1);
        check("hold_grant", 32'(hba_mgrant), 32'h4);
        man_req = '0;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            check("hold_sel", 32'(hba_mgrant), 32'h4);
        end
        man_sel = '0;
        tick(1);
        check("hold_rel", 32'(hba_mgrant), 32'h0);
        tick(2);

        // simultaneous requests
        do_reset();
        auto_en = 4'b1010;
        tick(20);
        check("sim_count", 32'(gq.size() >= 3), 32'h1);
        if (gq.size() >= 3) begin
            check("sim_g0", 32'(gq[0]), 32'h2);
            check("sim_g1", 32'(gq[1]), 32'h8);
            check("sim_g2", 32'(gq[2]), 32'h2);
        end

        // fairness
        do_reset();
        auto_en = 4'b1111;
        tick(30);
        check("fair_count", 32'(gq.size() >= 5), 32'h1);
        if (gq.size() >= 5) begin
            check("fair_g0", 32'(gq[0]), 32'h1);
            check("fair_g1", 32'(gq[1]), 32'h2);
            check("fair_g2", 32'(gq[2]), 32'h4);
            check("fair_g3", 32'(gq[3]), 32'h8);
            check("fair_g4", 32'(gq[4]), 32'h1);
        end

        // mid-transfer reset
        do_reset();
        man_req = 4'b0010;
        man_sel = 4'b0010;
        tick(1);
        check("mid_grant", 32'(hba_mgrant), 32'h2);
        tick(1);
        hba_reset = 1'b0;
        #1;
        check("mid_rst_grant", 32'(hba_mgrant), 32'h0);
        check("mid_rst_sel", 32'(hba_select), 32'h0);
        check("mid_rst_abus", 32'(hba_abus), 32'h0);
        man_req = 4'b0110;
        man_sel = '0;
        tick(1);
        hba_reset = 1'b1;
        tick(1);
        check("mid_after", 32'(hba_mgrant), 32'h2);
        man_req = '0;
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hba_arbiter.md
# hba_arbiter

Round-robin bus arbiter for the HBA bus. It accepts `master_request` from up to `NUM_MASTERS` HBA masters (`serial_fpga` is master 0) and issues exactly one `hba_mgrant`. It merges the granted master's `master_abus/rnw/select/dbus` onto the shared HBA bus that all slaves (`hba_gpio`, `hba_reg_bank`, …) consume. It replaces the top-level hard-wired grant handling and sits directly between the masters and the slave bus.

## Interface
Parameters:
- `NUM_MASTERS`, 4, number of master ports (1..8)
- `DBUS_WIDTH`, 8, data bus width
- `PERIPH_ADDR_WIDTH`, 4, peripheral address field width
- `REG_ADDR_WIDTH`, 8, register address field width
- `ADDR_WIDTH`, `PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH`, full address width

Ports:
- `hba_clk`  in  1  single clock; all logic on rising edge
- `hba_reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `master_request`  in  NUM_MASTERS  bit i = master i wants the bus
- `master_abus`  in  NUM_MASTERS*ADDR_WIDTH  master i address at slice i
- `master_rnw`  in  NUM_MASTERS  master i read(1)/write(0)
- `master_select`  in  NUM_MASTERS  master i transfer in progress
- `master_dbus`  in  NUM_MASTERS*DBUS_WIDTH  master i write data at slice i
- `hba_mgrant`  out  NUM_MASTERS  one-hot grant, registered
- `hba_abus`  out  ADDR_WIDTH  merged address to slaves
- `hba_rnw`  out  1  merged rnw
- `hba_select`  out  1  merged select
- `hba_dbus`  out  DBUS_WIDTH  merged write data

## Operation
- States: IDLE, OWNED, RELEASE.
- IDLE: `hba_mgrant`=0. If any request is set, pick the first requester, searching upward from `last+1` modulo NUM_MASTERS. Register its grant bit, store its index as `last`, and go to OWNED. With no request, stay in IDLE.
- OWNED: hold the grant while the owner's `master_request`=1 or `hba_select`=1. When both are 0, clear the grant and go to RELEASE. Requests from other masters never pre-empt the owner.
- RELEASE: `hba_mgrant`=0 for one cycle (bus turnaround), then go to IDLE unconditionally.
- Merge: each bus output is the OR over i of (master i signal AND `hba_mgrant[i]`), combinational. With no grant, all merged outputs are 0, as the HBA "zero when inactive" rule requires. A non-granted master's signals are fully masked.
- Round-robin: `last` resets to NUM_MASTERS-1, so master 0 has first priority after reset. If the owner re-requests, it ranks last among the current requesters.
- Reset (`hba_reset`=0, any cycle including mid-transfer): state=IDLE, `hba_mgrant`=0, `last`=NUM_MASTERS-1. All merged outputs go to 0 immediately. An in-flight transfer is abandoned; the slave sees `hba_select` fall.
- A request bit that drops before its grant arrives is treated as no request. A grant already issued in the same edge still passes through OWNED and RELEASE normally.

## Timing
- Request to grant: request sampled on edge N in IDLE → `hba_mgrant` high after edge N.
- Grant to bus: merged outputs follow the master's inputs in the same cycle (zero register latency).
- Release: owner's request and `hba_select` both 0 at edge M → grant low after M. RELEASE spans M..M+1. The earliest next grant is after edge M+2.
- Back-to-back transfers by different masters have a minimum gap of 2 ungranted cycles.
- Single requester throughput: one grant every 3 cycles minimum (OWNED ≥1 cycle, RELEASE, IDLE).

## Structure
- Shared package `hba_pkg`: default DBUS/PERIPH/REG address widths, state encoding (IDLE=2'd0, OWNED=2'd1, RELEASE=2'd2), and the `MAX_MASTERS`=8 constant.
- One sub-module, `hba_rr_pick`: combinational round-robin picker. Inputs: request vector and `last` index. Outputs: one-hot pick and a valid flag.
- The bus merge uses a generate loop in the top module.

## Test plan
- Single request: NUM_MASTERS=4, request=4'b0001 → grant=4'b0001 one cycle later. `hba_abus` equals master 0's `master_abus` (e.g. 12'h012) while granted. After request and select drop, grant=0 for 2 cycles.
- Simultaneous requests: request=4'b1010 held after reset → grant order 4'b0010, then 4'b1000, then 4'b0010. Each transfer is separated by the 2-cycle gap.
- Fairness: all four requesting continuously, each transfer 3 cycles long → grants rotate 0,1,2,3,0. No master waits more than 3 tenures.
- Masking: master 2 (not granted) drives `master_abus`=12'hFFF, `master_select`=1, `master_dbus`=8'hAA → `hba_abus`/`hba_select`/`hba_dbus` show only the owner's values (all 0 when no grant).
- Select hold: owner drops its request while `hba_select`=1 for 3 more cycles → grant stays high until the first edge where select=0, then RELEASE.
- Mid-transfer reset: pull `hba_reset` low during OWNED → grant and all merged outputs 0 asynchronously. After release, the first grant goes to the lowest-index requester.
